// File: rtl/txn_circular_buffer_if.sv
// Bus bundle for txn_circular_buffer: data/control requests in, status out.
interface txn_circular_buffer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  i_write_en;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_read_en;
    logic                  i_mark;
    logic                  i_commit;
    logic                  i_rollback;
    logic                  i_clear_errors;
    logic [DATA_WIDTH-1:0] o_data;
    logic [CW-1:0]         o_data_size;
    logic [CW-1:0]         o_used;
    logic                  o_empty;
    logic                  o_full;
    logic                  o_almost_full;
    logic                  o_almost_empty;
    logic                  o_txn_open;
    logic                  o_overrun;
    logic                  o_underrun;
    logic                  o_invalid_op;

    // Producer/consumer side
    modport master (
        output i_write_en, i_data, i_read_en, i_mark, i_commit, i_rollback, i_clear_errors,
        input  o_data, o_data_size, o_used, o_empty, o_full, o_almost_full, o_almost_empty,
               o_txn_open, o_overrun, o_underrun, o_invalid_op
    );

    // Buffer side
    modport slave (
        input  i_write_en, i_data, i_read_en, i_mark, i_commit, i_rollback, i_clear_errors,
        output o_data, o_data_size, o_used, o_empty, o_full, o_almost_full, o_almost_empty,
               o_txn_open, o_overrun, o_underrun, o_invalid_op
    );
endinterface

// File: rtl/txn_circular_buffer.sv
// Full-capacity circular buffer with transactional writes (mark/commit/rollback).
// Readers only see entries up to cmt_ptr; uncommitted writes still occupy space.
module txn_circular_buffer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned AFULL_LEVEL  = DEPTH - 4,
    parameter int unsigned AEMPTY_LEVEL = 4
) (
    input logic                   i_clk,
    input logic                   i_rst,
    txn_circular_buffer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cmt_ptr_q, cmt_ptr_d;
    logic          txn_open_q, txn_open_d;
    logic          overrun_q, overrun_d;
    logic          underrun_q, underrun_d;
    logic          invalid_q, invalid_d;

    logic [CW-1:0] used, committed, wr_ptr_post;
    logic          ctrl_multi, do_mark, do_commit, do_rollback, bad_ctrl;
    logic          rd_acc, has_room, wr_acc;

    assign used      = wr_ptr_q - rd_ptr_q;
    assign committed = cmt_ptr_q - rd_ptr_q;

    // Decode data ops and control commands, compute next state
    always_comb begin
        ctrl_multi  = (bus.i_mark & bus.i_commit) | (bus.i_mark & bus.i_rollback) |
                      (bus.i_commit & bus.i_rollback);
        do_mark     = bus.i_mark & ~ctrl_multi & ~txn_open_q;
        do_commit   = bus.i_commit & ~ctrl_multi & txn_open_q;
        do_rollback = bus.i_rollback & ~ctrl_multi & txn_open_q;
        bad_ctrl    = ctrl_multi | (bus.i_mark & ~ctrl_multi & txn_open_q) |
                      ((bus.i_commit | bus.i_rollback) & ~ctrl_multi & ~txn_open_q);

        // A write into a full buffer is allowed only if the head is popped this cycle
        rd_acc      = bus.i_read_en && (committed != '0);
        has_room    = (used != CW'(DEPTH)) || rd_acc;
        wr_acc      = bus.i_write_en & has_room & ~do_rollback;
        wr_ptr_post = wr_ptr_q + CW'(wr_acc);

        rd_ptr_d    = rd_ptr_q + CW'(rd_acc);
        wr_ptr_d    = do_rollback ? cmt_ptr_q : wr_ptr_post;

        // Outside a transaction cmt_ptr tracks wr_ptr; a mark freezes it at the
        // pre-write value so a same-cycle write belongs to the new transaction
        cmt_ptr_d  = cmt_ptr_q;
        txn_open_d = txn_open_q;
        if (txn_open_q) begin
            if (do_commit) begin
                cmt_ptr_d  = wr_ptr_post;
                txn_open_d = 1'b0;
            end else if (do_rollback) begin
                txn_open_d = 1'b0;
            end
        end else if (do_mark) begin
            txn_open_d = 1'b1;
        end else begin
            cmt_ptr_d = wr_ptr_post;
        end

        // Sticky flags: a same-cycle error event wins over clear
        overrun_d  = (overrun_q & ~bus.i_clear_errors) |
                     (bus.i_write_en & ~has_room & ~do_rollback);
        underrun_d = (underrun_q & ~bus.i_clear_errors) | (bus.i_read_en & ~rd_acc);
        invalid_d  = (invalid_q & ~bus.i_clear_errors) | bad_ctrl;
    end

    // Pointer, transaction and error state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            txn_open_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            txn_open_q <= txn_open_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            invalid_q  <= invalid_d;
        end
    end

    // Storage array, not reset
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.i_data;
        end
    end

    assign bus.o_data         = mem[rd_ptr_q[AW-1:0]];
    assign bus.o_data_size    = committed;
    assign bus.o_used         = used;
    assign bus.o_empty        = (committed == '0);
    assign bus.o_full         = (used == CW'(DEPTH));
    assign bus.o_almost_full  = (used >= CW'(AFULL_LEVEL));
    assign bus.o_almost_empty = (committed <= CW'(AEMPTY_LEVEL));
    assign bus.o_txn_open     = txn_open_q;
    assign bus.o_overrun      = overrun_q;
    assign bus.o_underrun     = underrun_q;
    assign bus.o_invalid_op   = invalid_q;
endmodule

// File: tb/tb_txn_circular_buffer.sv
// Directed bench for txn_circular_buffer at DEPTH=8, DATA_WIDTH=8.
module tb_txn_circular_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    txn_circular_buffer_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

    txn_circular_buffer #(
        .DATA_WIDTH   (8),
        .DEPTH        (8),
        .AFULL_LEVEL  (4),
        .AEMPTY_LEVEL (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic idle();
        bus.i_write_en     = 1'b0;
        bus.i_data         = 8'h00;
        bus.i_read_en      = 1'b0;
        bus.i_mark         = 1'b0;
        bus.i_commit       = 1'b0;
        bus.i_rollback     = 1'b0;
        bus.i_clear_errors = 1'b0;
    endtask

    // Apply the currently driven inputs for one edge, then sample 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: empty/full/aempty got %b%b%b want 101",
                     bus.o_empty, bus.o_full, bus.o_almost_empty);
        end
        n_checks++;
        if (bus.o_data_size !== 4'd0 || bus.o_used !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_counts: size %0d used %0d want 0 0", bus.o_data_size, bus.o_used);
        end
        n_checks++;
        if ({bus.o_txn_open, bus.o_overrun, bus.o_underrun, bus.o_invalid_op} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_status: got %b%b%b%b want 0000", bus.o_txn_open,
                     bus.o_overrun, bus.o_underrun, bus.o_invalid_op);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            bus.i_write_en = 1'b1;
            bus.i_data     = vals[i];
            tick();
        end
        n_checks++;
        if (bus.o_data_size !== 4'd3 || bus.o_used !== 4'd3) begin
            n_fail++;
            $display("FAIL basic_count: size %0d used %0d want 3 3", bus.o_data_size, bus.o_used);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.o_data !== vals[i] || bus.o_data_size !== 4'(3 - i)) begin
                n_fail++;
                $display("FAIL basic_read%0d: data %h size %0d want %h %0d", i, bus.o_data,
                         bus.o_data_size, vals[i], 3 - i);
            end
            bus.i_read_en = 1'b1;
            tick();
        end
        n_checks++;
        if (bus.o_empty !== 1'b1 || bus.o_data_size !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_empty: empty %b size %0d want 1 0", bus.o_empty, bus.o_data_size);
        end
        n_checks++;
        if ({bus.o_overrun, bus.o_underrun, bus.o_invalid_op} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_flags: got %b%b%b want 000", bus.o_overrun, bus.o_underrun,
                     bus.o_invalid_op);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            bus.i_write_en = 1'b1;
            bus.i_data     = 8'(8'h40 + i);
            tick();
        end
        n_checks++;
        if (bus.o_full !== 1'b1 || bus.o_used !== 4'd8 || bus.o_almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state: full %b used %0d afull %b want 1 8 1", bus.o_full,
                     bus.o_used, bus.o_almost_full);
        end
        n_checks++;
        if (bus.o_almost_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL full_aempty: got %b want 0", bus.o_almost_empty);
        end
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'h99;
        tick();
        n_checks++;
        if (bus.o_overrun !== 1'b1 || bus.o_used !== 4'd8) begin
            n_fail++;
            $display("FAIL full_overrun: ovr %b used %0d want 1 8", bus.o_overrun, bus.o_used);
        end
        bus.i_clear_errors = 1'b1;
        tick();
        n_checks++;
        if (bus.o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL full_clear: ovr %b want 0", bus.o_overrun);
        end
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'h48;
        bus.i_read_en  = 1'b1;
        tick();
        n_checks++;
        if (bus.o_used !== 4'd8 || bus.o_overrun !== 1'b0 || bus.o_data !== 8'h41) begin
            n_fail++;
            $display("FAIL full_wr_rd: used %0d ovr %b data %h want 8 0 41", bus.o_used,
                     bus.o_overrun, bus.o_data);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.o_data !== 8'(8'h41 + i)) begin
                n_fail++;
                $display("FAIL full_drain%0d: data %h want %h", i, bus.o_data, 8'h41 + i);
            end
            bus.i_read_en = 1'b1;
            tick();
        end
        n_checks++;
        if (bus.o_empty !== 1'b1 || bus.o_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL full_end: empty %b udr %b want 1 0", bus.o_empty, bus.o_underrun);
        end
    endtask

    task automatic test_commit();
        bus.i_mark     = 1'b1;
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'hA0;
        tick();
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'hA1;
        tick();
        n_checks++;
        if (bus.o_used !== 4'd2 || bus.o_data_size !== 4'd0 || bus.o_empty !== 1'b1 ||
            bus.o_txn_open !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_staged: used %0d size %0d empty %b txn %b want 2 0 1 1",
                     bus.o_used, bus.o_data_size, bus.o_empty, bus.o_txn_open);
        end
        bus.i_read_en = 1'b1;
        tick();
        n_checks++;
        if (bus.o_underrun !== 1'b1 || bus.o_used !== 4'd2) begin
            n_fail++;
            $display("FAIL commit_underrun: udr %b used %0d want 1 2", bus.o_underrun, bus.o_used);
        end
        bus.i_commit = 1'b1;
        tick();
        n_checks++;
        if (bus.o_data_size !== 4'd2 || bus.o_data !== 8'hA0 || bus.o_txn_open !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_publish: size %0d data %h txn %b want 2 a0 0",
                     bus.o_data_size, bus.o_data, bus.o_txn_open);
        end
        bus.i_clear_errors = 1'b1;
        bus.i_read_en      = 1'b1;
        tick();
        n_checks++;
        if (bus.o_data !== 8'hA1 || bus.o_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_second: data %h udr %b want a1 0", bus.o_data, bus.o_underrun);
        end
        bus.i_read_en = 1'b1;
        tick();
    endtask

    task automatic test_rollback();
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'h05;
        tick();
        bus.i_mark = 1'b1;
        tick();
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'hB0;
        tick();
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'hB1;
        tick();
        n_checks++;
        if (bus.o_used !== 4'd3 || bus.o_data_size !== 4'd1) begin
            n_fail++;
            $display("FAIL rb_staged: used %0d size %0d want 3 1", bus.o_used, bus.o_data_size);
        end
        bus.i_rollback = 1'b1;
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'hB2;
        tick();
        n_checks++;
        if (bus.o_used !== 4'd1 || bus.o_data_size !== 4'd1 || bus.o_txn_open !== 1'b0 ||
            bus.o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_discard: used %0d size %0d txn %b ovr %b want 1 1 0 0",
                     bus.o_used, bus.o_data_size, bus.o_txn_open, bus.o_overrun);
        end
        n_checks++;
        if (bus.o_data !== 8'h05) begin
            n_fail++;
            $display("FAIL rb_head: data %h want 05", bus.o_data);
        end
        bus.i_read_en = 1'b1;
        tick();
        n_checks++;
        if (bus.o_empty !== 1'b1 || bus.o_used !== 4'd0) begin
            n_fail++;
            $display("FAIL rb_drain: empty %b used %0d want 1 0", bus.o_empty, bus.o_used);
        end
    endtask

    task automatic test_invalid();
        bus.i_commit = 1'b1;
        tick();
        n_checks++;
        if (bus.o_invalid_op !== 1'b1 || bus.o_txn_open !== 1'b0 || bus.o_used !== 4'd0) begin
            n_fail++;
            $display("FAIL inv_commit: inv %b txn %b used %0d want 1 0 0", bus.o_invalid_op,
                     bus.o_txn_open, bus.o_used);
        end
        bus.i_clear_errors = 1'b1;
        tick();
        bus.i_mark     = 1'b1;
        bus.i_rollback = 1'b1;
        tick();
        n_checks++;
        if (bus.o_invalid_op !== 1'b1 || bus.o_txn_open !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_multi: inv %b txn %b want 1 0", bus.o_invalid_op, bus.o_txn_open);
        end
        bus.i_clear_errors = 1'b1;
        tick();
        bus.i_mark = 1'b1;
        tick();
        n_checks++;
        if (bus.o_invalid_op !== 1'b0 || bus.o_txn_open !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_mark1: inv %b txn %b want 0 1", bus.o_invalid_op, bus.o_txn_open);
        end
        bus.i_mark = 1'b1;
        tick();
        n_checks++;
        if (bus.o_invalid_op !== 1'b1 || bus.o_txn_open !== 1'b1 || bus.o_used !== 4'd0) begin
            n_fail++;
            $display("FAIL inv_mark2: inv %b txn %b used %0d want 1 1 0", bus.o_invalid_op,
                     bus.o_txn_open, bus.o_used);
        end
        bus.i_commit = 1'b1;
        tick();
        // Clear together with a fresh error: the set must win
        bus.i_clear_errors = 1'b1;
        bus.i_rollback     = 1'b1;
        tick();
        n_checks++;
        if (bus.o_invalid_op !== 1'b1 || bus.o_txn_open !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_set_wins: inv %b txn %b want 1 0", bus.o_invalid_op,
                     bus.o_txn_open);
        end
        bus.i_clear_errors = 1'b1;
        tick();
        n_checks++;
        if ({bus.o_overrun, bus.o_underrun, bus.o_invalid_op} !== 3'b000) begin
            n_fail++;
            $display("FAIL inv_clear: got %b%b%b want 000", bus.o_overrun, bus.o_underrun,
                     bus.o_invalid_op);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            bus.i_write_en = 1'b1;
            bus.i_data     = 8'(8'hC0 + i);
            tick();
        end
        bus.i_mark = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.i_write_en = 1'b1;
            bus.i_data     = 8'(8'hD0 + i);
            tick();
        end
        n_checks++;
        if (bus.o_used !== 4'd5 || bus.o_txn_open !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_staged: used %0d txn %b want 5 1", bus.o_used, bus.o_txn_open);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_used !== 4'd0 || bus.o_data_size !== 4'd0 || bus.o_empty !== 1'b1 ||
            bus.o_txn_open !== 1'b0 || bus.o_almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: used %0d size %0d empty %b txn %b aempty %b want 0 0 1 0 1",
                     bus.o_used, bus.o_data_size, bus.o_empty, bus.o_txn_open,
                     bus.o_almost_empty);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'h77;
        tick();
        n_checks++;
        if (bus.o_data !== 8'h77 || bus.o_data_size !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_after: data %h size %0d want 77 1", bus.o_data, bus.o_data_size);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_full();
        test_commit();
        test_rollback();
        test_invalid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
